mle_chi_eval: RTL and testbench

Consumer end of the prover shim's chi interface. It takes the `z1_chi` table (all 2^nGateBits evaluations of the eq-polynomial at `z1`) and a vector of gate values. It evaluates the multilinear extension of those values at `z1` by computing the inner product sum(chi[i]·val[i]) mod `F_Q`. The block sits directly downstream of `prover_shim` in the prover layer pipeline and time-multiplexes one modular multiply-accumulate datapath across all gates.

---
 rtl/mle_chi_pkg.sv | 9 +
 rtl/mle_chi_eval_mac.sv | 27 ++
 rtl/mle_chi_eval.sv | 72 +++++++
 tb/tb_mle_chi_eval.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mle_chi_pkg.sv
// Field constants shared with prover_shim: arithmetic is over the Mersenne
// prime 2^61-1, so the product reduces mod F_Q by folding its halves.
package mle_chi_pkg;

  localparam int                 F_NBITS = 61;
  localparam logic [F_NBITS-1:0] F_Q     = {F_NBITS{1'b1}};
  localparam int                 F_PBITS = 2 * F_NBITS;

endpackage

// File: rtl/mle_chi_eval_mac.sv
// Combinational (a + b*c) mod F_Q. Operands must already be reduced.
module field_mac
  import mle_chi_pkg::*;
(
  input  logic [F_NBITS-1:0] i_a,
  input  logic [F_NBITS-1:0] i_b,
  input  logic [F_NBITS-1:0] i_c,
  output logic [F_NBITS-1:0] o_sum
);

  logic [F_PBITS-1:0] w_prod;
  logic [F_NBITS+1:0] w_sum;
  logic [F_NBITS:0]   w_fold;

  // 2^61 == 1 mod F_Q, so the product's high half adds onto the low half.
  // The three-term sum stays below 3*2^61; one more fold plus a single
  // conditional subtract finishes the reduction.
  assign w_prod = F_PBITS'(i_b) * F_PBITS'(i_c);
  assign w_sum  = {2'b00, i_a}
                + {2'b00, w_prod[F_NBITS-1:0]}
                + {2'b00, w_prod[F_PBITS-1:F_NBITS]};
  assign w_fold = {1'b0, w_sum[F_NBITS-1:0]}
                + {{(F_NBITS-1){1'b0}}, w_sum[F_NBITS+1:F_NBITS]};
  assign o_sum  = (w_fold >= {1'b0, F_Q}) ? F_NBITS'(w_fold - {1'b0, F_Q})
                                          : w_fold[F_NBITS-1:0];

endmodule

// File: rtl/mle_chi_eval.sv
// Evaluates the multilinear extension of vals at z1 as sum(chi[i]*vals[i])
// mod F_Q, sharing one field MAC across all gates (one gate per cycle).
module mle_chi_eval
  import mle_chi_pkg::*;
#(
  parameter  int nGateBits = 6,
  localparam int nGates    = 1 << nGateBits
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] z1_chi [nGates],
  input  logic [F_NBITS-1:0] vals   [nGates],
  output logic [F_NBITS-1:0] result,
  output logic               ready
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [nGateBits-1:0] r_idx;
  logic [F_NBITS-1:0]   r_acc;
  logic [F_NBITS-1:0]   w_macOut;
  logic                 w_lastIdx;

  assign w_lastIdx = (r_idx == nGateBits'(nGates - 1));

  field_mac u_mac (
    .i_a   (r_acc),
    .i_b   (z1_chi[r_idx]),
    .i_c   (vals[r_idx]),
    .o_sum (w_macOut)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (en)        w_nextState = RUN;
      RUN:     if (w_lastIdx) w_nextState = IDLE;
      default:                w_nextState = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == IDLE);
  end

  // idx wraps back to 0 on the final gate, so no explicit clear is needed there.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_acc <= '0;
      r_idx <= '0;
    end else if (r_state == IDLE) begin
      if (en) begin
        r_acc <= '0;
        r_idx <= '0;
      end
    end else begin
      r_acc <= w_macOut;
      r_idx <= r_idx + 1'b1;
    end
  end

  assign result = r_acc;

endmodule

// File: tb/tb_mle_chi_eval.sv
// Directed bench for mle_chi_eval: chi tables come from a behavioural eq-poly
// model and expected sums from a % based field model.
module tb_mle_chi_eval;
  import mle_chi_pkg::*;

  localparam int NB = 6;
  localparam int NG = 1 << NB;
  localparam int BUDGET = 200;

  logic               clk;
  logic               rstb;
  logic               en;
  logic [F_NBITS-1:0] chiTab [NG];
  logic [F_NBITS-1:0] valTab [NG];
  logic [F_NBITS-1:0] result;
  logic               ready;

  logic [F_NBITS-1:0] zVec [NB];
  logic [F_NBITS-1:0] expVal;
  int                 cycles;
  int                 vectors;
  int                 miscompares;

  mle_chi_eval #(.nGateBits(NB)) dut (
    .clk    (clk),
    .rstb   (rstb),
    .en     (en),
    .z1_chi (chiTab),
    .vals   (valTab),
    .result (result),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [F_NBITS-1:0] mulMod(input logic [F_NBITS-1:0] a,
                                                input logic [F_NBITS-1:0] b);
    logic [F_PBITS-1:0] p;
    p = (F_PBITS'(a) * F_PBITS'(b)) % F_PBITS'(F_Q);
    return p[F_NBITS-1:0];
  endfunction

  function automatic logic [F_NBITS-1:0] addMod(input logic [F_NBITS-1:0] a,
                                                input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, F_Q};
    return s[F_NBITS-1:0];
  endfunction

  function automatic logic [F_NBITS-1:0] randField();
    logic [63:0] r;
    r = {$urandom, $urandom} % {3'b000, F_Q};
    return r[F_NBITS-1:0];
  endfunction

  // chi[i] = prod_j (bit j of i ? z_j : 1 - z_j)
  task automatic buildChi();
    for (int i = 0; i < NG; i++) begin
      logic [F_NBITS-1:0] v;
      v = 1;
      for (int j = 0; j < NB; j++) begin
        if (((i >> j) & 1) == 1) v = mulMod(v, zVec[j]);
        else                     v = mulMod(v, addMod(1, F_Q - zVec[j]));
      end
      chiTab[i] = v;
    end
  endtask

  task automatic randomZ();
    for (int j = 0; j < NB; j++) zVec[j] = randField();
    buildChi();
  endtask

  function automatic logic [F_NBITS-1:0] modelSum();
    logic [F_NBITS-1:0] s;
    s = 0;
    for (int i = 0; i < NG; i++) s = addMod(s, mulMod(chiTab[i], valTab[i]));
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse en for one edge, then count edges until ready returns; optionally
  // re-pulse en partway through the run.
  task automatic applyStimulus(input int pulseAt, output int n);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    n = 0;
    while (n < BUDGET) begin
      @(posedge clk);
      #1 n++;
      en = (n == pulseAt);
      if (ready) break;
    end
    en = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    en          = 1'b0;
    rstb        = 1'b0;
    for (int i = 0; i < NG; i++) begin
      chiTab[i] = '0;
      valTab[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", 64'(ready), 64'd1);
    checkOutput("reset_result", 64'(result), 64'd0);

    // z1 = 0 selects gate 0 only
    for (int j = 0; j < NB; j++) zVec[j] = '0;
    buildChi();
    for (int i = 0; i < NG; i++) valTab[i] = randField();
    valTab[0] = 61'h1234;
    applyStimulus(-1, cycles);
    checkOutput("latency_cycles", 64'(cycles), 64'd64);
    checkOutput("chi_zero_z", 64'(result), 64'h1234);

    randomZ();
    for (int i = 0; i < NG; i++) valTab[i] = 61'd1;
    applyStimulus(-1, cycles);
    checkOutput("chi_sums_to_one", 64'(result), 64'd1);

    randomZ();
    for (int i = 0; i < NG; i++) valTab[i] = '0;
    valTab[37] = 61'd1;
    applyStimulus(-1, cycles);
    checkOutput("onehot_37", 64'(result), 64'(chiTab[37]));
    valTab[37] = F_Q - 1;
    expVal = (chiTab[37] == 0) ? '0 : F_Q - chiTab[37];
    applyStimulus(-1, cycles);
    checkOutput("onehot_37_neg", 64'(result), 64'(expVal));

    randomZ();
    for (int i = 0; i < NG; i++) valTab[i] = randField();
    expVal = modelSum();
    applyStimulus(20, cycles);
    checkOutput("repulse_cycles", 64'(cycles), 64'd64);
    checkOutput("repulse_result", 64'(result), 64'(expVal));
    @(negedge clk);
    checkOutput("repulse_no_restart", 64'(ready), 64'd1);

    // reset asserted mid-run discards the partial sum immediately
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (30) @(posedge clk);
    #1 rstb = 1'b0;
    #1;
    checkOutput("midrun_reset_ready", 64'(ready), 64'd1);
    checkOutput("midrun_reset_result", 64'(result), 64'd0);
    @(negedge clk);
    rstb = 1'b1;
    applyStimulus(-1, cycles);
    checkOutput("post_reset_result", 64'(result), 64'(expVal));

    // chained: ready's rising edge starts the next evaluation one edge later
    randomZ();
    for (int i = 0; i < NG; i++) valTab[i] = randField();
    expVal = modelSum();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    for (int t = 0; t < 7; t++) begin
      cycles = 0;
      while (cycles < BUDGET) begin
        @(posedge clk);
        #1 cycles++;
        if (ready) break;
      end
      checkOutput($sformatf("chain%0d_cycles", t), 64'(cycles), 64'd64);
      checkOutput($sformatf("chain%0d_result", t), 64'(result), 64'(expVal));
      if (t < 6) begin
        randomZ();
        for (int i = 0; i < NG; i++) valTab[i] = randField();
        expVal = modelSum();
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
